// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one radix-4 Booth 16x16 signed multiplier among NUM_REQ requesters.
// Optional completed-operation counter (op_count port) enabled by defining MULT_SHARE_STATS_EN.

module booth_multiplier_16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] product_o
);
    logic [31:0] a_ext;
    logic [16:0] b_ext;
    logic [2:0]  triple;
    logic [31:0] pp;
    logic [31:0] acc;

    always_comb begin
        a_ext  = {{16{a_i[15]}}, a_i};
        b_ext  = {b_i, 1'b0};
        acc    = '0;
        triple = '0;
        pp     = '0;
        // Each overlapping bit triple of B selects 0, +-A or +-2A for its radix-4 digit.
        for (int i = 0; i < 8; i++) begin
            triple = b_ext[2*i +: 3];
            case (triple)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = 32'd0 - (a_ext << 1);
                3'b101, 3'b110: pp = 32'd0 - a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2*i));
        end
        product_o = acc;
    end
endmodule

module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_product,
    output logic [ID_W-1:0]       rsp_id
`ifdef MULT_SHARE_STATS_EN
    ,
    output logic [31:0]           op_count
`endif
);
    logic              s1_valid_q, s1_valid_d;
    logic [15:0]       s1_a_q, s1_a_d;
    logic [15:0]       s1_b_q, s1_b_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_product_q, rsp_product_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [31:0]       op_count_q, op_count_d;

    logic              s2_free, s1_adv, s1_free;
    logic              grant_found, grant;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W:0]     cand_sum;
    logic [NUM_REQ-1:0] grant_oh;
    logic [31:0]       mult_product;

    booth_multiplier_16 u_mult (
        .a_i       (s1_a_q),
        .b_i       (s1_b_q),
        .product_o (mult_product)
    );

    assign s2_free = !rsp_valid_q || rsp_ready;
    assign s1_adv  = s1_valid_q && s2_free;
    assign s1_free = !s1_valid_q || s1_adv;

    // Circular search starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_sum    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_sum = {1'b0, last_id_q} + (ID_W+1)'(off);
            if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand_sum[ID_W-1:0];
            end
        end
        grant    = s1_free && grant_found;
        grant_oh = '0;
        if (grant) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant_oh;

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_a_d        = s1_a_q;
        s1_b_d        = s1_b_q;
        s1_id_d       = s1_id_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_product_d = rsp_product_q;
        rsp_id_d      = rsp_id_q;
        last_id_d     = last_id_q;
        op_count_d    = op_count_q;

        if (s1_adv) begin
            rsp_product_d = mult_product;
            rsp_id_d      = s1_id_q;
            rsp_valid_d   = 1'b1;
            s1_valid_d    = 1'b0;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (grant) begin
            s1_valid_d = 1'b1;
            s1_id_d    = grant_id;
            last_id_d  = grant_id;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_oh[i]) begin
                    s1_a_d = req_a[16*i +: 16];
                    s1_b_d = req_b[16*i +: 16];
                end
            end
        end

        if (rsp_valid_q && rsp_ready) begin
            op_count_d = op_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_id_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_product_q <= '0;
            rsp_id_q      <= '0;
            last_id_q     <= ID_W'(NUM_REQ - 1);
            op_count_q    <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_id_q       <= s1_id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            rsp_id_q      <= rsp_id_d;
            last_id_q     <= last_id_d;
            op_count_q    <= op_count_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign rsp_id      = rsp_id_q;
`ifdef MULT_SHARE_STATS_EN
    assign op_count    = op_count_q;
`else
    logic unused_count;
    assign unused_count = ^op_count_q;
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized self-checking bench for mult_share_arbiter against a queue-based reference model.
// Define MULT_SHARE_STATS_EN to also check the op_count port.

module tb_mult_share_arbiter;
    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_product;
    logic [1:0]  rsp_id;
`ifdef MULT_SHARE_STATS_EN
    logic [31:0] op_count;
`endif

    mult_share_arbiter #(.NUM_REQ(NREQ), .ID_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id)
`ifdef MULT_SHARE_STATS_EN
        ,
        .op_count    (op_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: ordered in-flight ops; the head is visible only once it has
    // survived one edge in flight.
    int          q_id[$];
    logic [31:0] q_prod[$];
    bit          head_fresh = 1'b0;
    int          m_last = NREQ - 1;
    int unsigned m_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_id.delete();
        q_prod.delete();
        head_fresh = 1'b0;
        m_last = NREQ - 1;
        m_count = 0;
    endtask

    // Called just after a negedge with inputs applied; returns the granted index or -1.
    task automatic tick(output int gnt);
        bit          exp_rv, pop;
        int          n_before;
        logic [3:0]  exp_ready;
        logic [15:0] a, b;
        #1;
        exp_rv = (q_id.size() > 0) && !head_fresh;
        pop    = exp_rv && rsp_ready;
        gnt    = -1;
        if (q_id.size() - int'(pop) < 2) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (gnt < 0 && req_valid[i]) gnt = i;
            end
        end
        exp_ready = (gnt >= 0) ? 4'(1 << gnt) : 4'd0;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            check_eq("rsp_product", rsp_product, q_prod[0]);
            check_eq("rsp_id", 32'(rsp_id), 32'(q_id[0]));
        end
`ifdef MULT_SHARE_STATS_EN
        check_eq("op_count", op_count, m_count);
`endif
        @(posedge clk);
        n_before = q_id.size();
        if (pop) begin
            void'(q_id.pop_front());
            void'(q_prod.pop_front());
            m_count++;
        end
        if (gnt >= 0) begin
            a = req_a[16*gnt +: 16];
            b = req_b[16*gnt +: 16];
            q_id.push_back(gnt);
            q_prod.push_back(32'($signed(a) * $signed(b)));
            m_last = gnt;
        end
        head_fresh = (q_id.size() > 0) && !(pop ? (n_before >= 2) : (n_before >= 1));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        int g;
        req_valid = '0;
        for (int i = 0; i < n; i++) tick(g);
    endtask

    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b);
        int g;
        int budget;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        budget = 20;
        g = -1;
        while (g != id && budget > 0) begin
            tick(g);
            budget--;
        end
        if (g != id) check_eq("issue_timeout", 32'(g), 32'(id));
        req_valid = '0;
    endtask

    initial begin
        int g;
        int grants;
        int rr_exp[6];
        rr_exp = '{0, 1, 2, 3, 0, 1};
        model_reset();
        #12;
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_rsp_product", rsp_product, 32'd0);
        check_eq("reset_rsp_id", 32'(rsp_id), 32'd0);
`ifdef MULT_SHARE_STATS_EN
        check_eq("reset_op_count", op_count, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        idle(1);

        // Single op: visible two cycles after acceptance.
        issue(1, 16'd10097, 16'd3943);
        tick(g);
        check_eq("single_valid", 32'(rsp_valid), 32'd1);
        check_eq("single_prod", rsp_product, 32'd39812471);
        check_eq("single_id", 32'(rsp_id), 32'd1);
        idle(2);

        // Signed corners.
        issue(0, -16'sd24576, 16'sd2);
        issue(0, 16'h8000, 16'h8000);
        check_eq("corner_neg_prod", rsp_product, 32'hFFFF4000);
        tick(g);
        check_eq("corner_min_prod", rsp_product, 32'h40000000);
        issue(0, 16'hFFFF, 16'sd32767);
        idle(3);
        check_eq("corner_m1_prod", rsp_product, 32'hFFFF8001);

        // Backpressure: two grants then stall, responses stay put.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_a[15:0] = 16'd1234;
        req_b[15:0] = 16'd5678;
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            tick(g);
            if (g >= 0) grants++;
            req_a[15:0] = 16'(req_a[15:0] + ((g >= 0) ? 16'd1 : 16'd0));
        end
        check_eq("bp_grants", 32'(grants), 32'd2);
        req_valid = '0;
        rsp_ready = 1'b1;
        idle(4);

        // Reset with both stages full, then round-robin from requester 0.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) tick(g);
        check_eq("pre_reset_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_valid", 32'(rsp_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = 16'(100 + i);
            req_b[16*i +: 16] = 16'(-3 - i);
        end
        for (int i = 0; i < 6; i++) begin
            tick(g);
            check_eq("rr_order", 32'(g), 32'(rr_exp[i]));
        end
        idle(3);

        // Randomized traffic; requesters hold operands until granted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 2) == 0)) begin
                    req_valid[i] = 1'b1;
                    req_a[16*i +: 16] = 16'($urandom);
                    req_b[16*i +: 16] = 16'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        rsp_ready = 1'b1;
        idle(4);

`ifdef MULT_SHARE_STATS_EN
        #1;
        check_eq("stats_total", op_count, m_count);
        rst_n = 1'b0;
        #1;
        check_eq("stats_reset", op_count, 32'd0);
        rst_n = 1'b1;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
